// File: rtl/timer_pkg.sv
// Shared types for the countdown timer controller.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } timer_state_t;

endpackage

// File: rtl/cntr_udclr_nb.sv
// n-bit up/down counter with async clear and parallel load.
module cntr_udclr_nb #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         up,
  input  logic         ld,
  input  logic [n-1:0] D,
  output logic [n-1:0] count,
  output logic         rco
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)       count <= '0;
    else if (ld)   count <= D;
    else if (up)   count <= count + 1'b1;
    else           count <= count - 1'b1;
  end

  // High while another step is possible in the current direction
  assign rco = up ? ~&count : |count;

endmodule

// File: rtl/tick_gen.sv
// Prescaler: counts 0..div_q and wraps; tick marks the last count.
module tick_gen #(
  parameter int p = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [p-1:0] div,
  output logic         tick
);

  logic [p-1:0] psc;
  logic [p-1:0] div_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      psc   <= '0;
      div_q <= '0;
    end else if (load) begin
      psc   <= '0;
      div_q <= div;
    end else if (en) begin
      psc <= tick ? '0 : psc + 1'b1;
    end
  end

  assign tick = (psc == div_q);

endmodule

// File: rtl/cntr_timer_ctrl.sv
// Countdown timer: drives an external up/down counter via clr/ld/up/D,
// one decrement per prescaled tick, with expiry flag and auto-reload.
module cntr_timer_ctrl
  import timer_pkg::*;
#(
  parameter int n = 8,
  parameter int p = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_rl,
  input  logic [n-1:0] preset,
  input  logic [p-1:0] psc_div,
  input  logic         irq_ack,
  input  logic [n-1:0] cnt_count,
  input  logic         cnt_rco,
  output logic         cnt_clr,
  output logic         cnt_ld,
  output logic         cnt_up,
  output logic [n-1:0] cnt_D,
  output logic         busy,
  output logic         expired,
  output logic         irq
);

  timer_state_t state;
  timer_state_t nxt;
  logic         tick;

  tick_gen #(.p(p)) u_tick (
    .clk  (clk),
    .clr  (clr),
    .load (state == LOAD),
    .en   (state == RUN),
    .div  (psc_div),
    .tick (tick)
  );

  assign cnt_clr = clr;
  assign cnt_up  = 1'b0;

  // Pausing = reloading the counter's own value
  always_comb begin
    cnt_ld = 1'b1;
    cnt_D  = cnt_count;
    case (state)
      LOAD:    cnt_D  = preset;
      RUN:     cnt_ld = !(tick && cnt_rco);
      default: ;
    endcase
  end

  always_comb begin
    nxt = state;
    if (state == IDLE) begin
      if (start) nxt = LOAD;
    end else if (stop) begin
      nxt = IDLE;
    end else if (start) begin
      nxt = LOAD;
    end else begin
      case (state)
        LOAD:    nxt = RUN;
        RUN:     if (!cnt_rco) nxt = DONE;
        DONE:    nxt = auto_rl ? LOAD : IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      busy    <= 1'b0;
      expired <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state   <= nxt;
      busy    <= (nxt == LOAD) || (nxt == RUN);
      expired <= (nxt == DONE);
      if (state == DONE)  irq <= 1'b1;
      else if (irq_ack)   irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cntr_timer_ctrl.sv
// Scoreboard bench: timer controller driving an 8-bit up/down counter.
module tb_cntr_timer_ctrl;

  localparam int N = 8;
  localparam int P = 16;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         auto_rl = 1'b0;
  logic [N-1:0] preset = '0;
  logic [P-1:0] psc_div = '0;
  logic         irq_ack = 1'b0;
  logic [N-1:0] cnt_count;
  logic         cnt_rco;
  logic         cnt_clr;
  logic         cnt_ld;
  logic         cnt_up;
  logic [N-1:0] cnt_D;
  logic         busy;
  logic         expired;
  logic         irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cntr_timer_ctrl #(.n(N), .p(P)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .stop      (stop),
    .auto_rl   (auto_rl),
    .preset    (preset),
    .psc_div   (psc_div),
    .irq_ack   (irq_ack),
    .cnt_count (cnt_count),
    .cnt_rco   (cnt_rco),
    .cnt_clr   (cnt_clr),
    .cnt_ld    (cnt_ld),
    .cnt_up    (cnt_up),
    .cnt_D     (cnt_D),
    .busy      (busy),
    .expired   (expired),
    .irq       (irq)
  );

  cntr_udclr_nb #(.n(N)) u_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .up    (cnt_up),
    .ld    (cnt_ld),
    .D     (cnt_D),
    .count (cnt_count),
    .rco   (cnt_rco)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every expired pulse must match the next expected cycle stamp
  always @(negedge clk) begin
    if (!clr && expired) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_expired cyc=%0d", cyc);
      end else begin
        int e;
        e = sb.pop_front();
        if (cyc != e || cnt_count != 0) begin
          errors++;
          $display("FAIL expired_at got_cyc=%0d want_cyc=%0d count=%0d",
                   cyc, e, cnt_count);
        end
      end
    end
  end

  task automatic wait_size(input int n);
    int t = 0;
    while (sb.size() > n && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    if (sb.size() > n) begin
      chk("sb_timeout", sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic pulse_start(input int pv, input int dv, input logic ar,
                             output int k0);
    @(negedge clk);
    preset  = N'(pv);
    psc_div = P'(dv);
    auto_rl = ar;
    start   = 1'b1;
    @(posedge clk); #1;
    k0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One-shot run: count after edge e0+m is max(pv - (m-1)/(dv+1), 0)
  task automatic run(input int pv, input int dv);
    int k0;
    int len;
    int ev;
    len = pv * (dv + 1) + 2;
    pulse_start(pv, dv, 1'b0, k0);
    sb.push_back(k0 + len);
    for (int m = 1; m <= len; m++) begin
      @(negedge clk);
      if (m == 1) chk("busy_run", busy, 1);
      if (m == 2) begin
        psc_div = P'($urandom_range(0, 7));
        preset  = N'($urandom);
      end
      ev = pv - (m - 1) / (dv + 1);
      if (ev < 0) ev = 0;
      chk($sformatf("count_p%0d_d%0d_m%0d", pv, dv, m), cnt_count, ev);
    end
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("irq_set", irq, 1);
    wait_size(0);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("irq_ack_clr", irq, 0);
  endtask

  initial begin
    int k0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_exp", expired, 0);
    chk("rst_count", cnt_count, 0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    run(3, 1);
    run(0, 0);
    for (int r = 0; r < 6; r++)
      run($urandom_range(0, 12), $urandom_range(0, 3));

    // Auto-reload: period LOAD + RUN x3 + DONE
    pulse_start(2, 0, 1'b1, k0);
    sb.push_back(k0 + 4);
    sb.push_back(k0 + 9);
    sb.push_back(k0 + 14);
    wait_size(2);
    @(negedge clk);
    @(negedge clk);
    chk("reload_count", cnt_count, 2);
    wait_size(0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    auto_rl = 1'b0;
    chk("auto_stop_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("auto_stop_count", cnt_count, 0);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("auto_irq_clr", irq, 0);

    // Stop mid-run at count 6: held, no expiry, no irq
    pulse_start(10, 1, 1'b0, k0);
    for (int m = 1; m <= 9; m++) @(negedge clk);
    chk("stop_at6", cnt_count, 6);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stop_hold", cnt_count, 6);
    end
    chk("stop_irq", irq, 0);

    // irq set wins over a concurrent ack
    irq_ack = 1'b1;
    pulse_start(1, 0, 1'b0, k0);
    sb.push_back(k0 + 3);
    wait_size(0);
    @(negedge clk);
    chk("irq_set_wins", irq, 1);
    @(negedge clk);
    chk("irq_ack_next", irq, 0);
    irq_ack = 1'b0;

    // Async reset between edges mid-run
    pulse_start(9, 2, 1'b0, k0);
    repeat (10) @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_count", cnt_count, 0);
    sb.delete();
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    run(4, 1);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
